// File: rtl/canvas_cursor_ctrl.sv
// Cursor and paint-stroke controller: it synchronises, debounces and edge-detects the buttons, moves the cursor and issues pixel writes over valid/ready.
// Define CANVAS_WRAP_EN to make the cursor wrap at the grid edges; without it the cursor clamps.
module canvas_cursor_ctrl #(
   parameter int X_W        = 6,
   parameter int Y_W        = 6,
   parameter int X_MAX      = 63,
   parameter int Y_MAX      = 63,
   parameter int DEB_CYCLES = 4,
   parameter int CH_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             btn_n,
   input  logic [2:0]             rgb_sel,
   input  logic                   brush,
   output logic                   px_valid,
   input  logic                   px_ready,
   output logic [X_W-1:0]         px_x,
   output logic [Y_W-1:0]         px_y,
   output logic [3*CH_BITS-1:0]   px_color,
   output logic [X_W-1:0]         cur_x,
   output logic [Y_W-1:0]         cur_y,
   output logic [3:0]             btn_deb,
   output logic [7:0]             drop_cnt
);

`ifdef CANVAS_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int             CNT_W    = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [X_W-1:0] X_LAST   = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST   = Y_W'(Y_MAX);

   logic [3:0]           r_btn_s1, r_btn_s2, r_btn_deb, r_btn_deb_q;
   logic [2:0]           r_rgb_s1, r_rgb_s2;
   logic                 r_brush_s1, r_brush_s2;
   logic [CNT_W-1:0]     r_cnt [4];
   logic [X_W-1:0]       r_cur_x, r_px_x;
   logic [Y_W-1:0]       r_cur_y, r_px_y;
   logic [3*CH_BITS-1:0] r_px_color;
   logic                 r_px_valid;
   logic [7:0]           r_drop_cnt;

   logic [3:0]           w_pulse;
   logic [X_W-1:0]       w_next_x;
   logic [Y_W-1:0]       w_next_y;
   logic                 w_move, w_slot_free, w_launch, w_drop;
   logic [3*CH_BITS-1:0] w_color;

   // Button bit order is {up, down, right, left}.
   assign w_pulse = r_btn_deb & ~r_btn_deb_q;

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_x = r_cur_x;
      w_next_y = r_cur_y;
      if (w_pulse[1] & ~w_pulse[0])
         w_next_x = (r_cur_x == X_LAST) ? (WRAP ? '0 : X_LAST) : r_cur_x + 1'b1;
      else if (w_pulse[0] & ~w_pulse[1])
         w_next_x = (r_cur_x == '0) ? (WRAP ? X_LAST : '0) : r_cur_x - 1'b1;
      if (w_pulse[2] & ~w_pulse[3])
         w_next_y = (r_cur_y == Y_LAST) ? (WRAP ? '0 : Y_LAST) : r_cur_y + 1'b1;
      else if (w_pulse[3] & ~w_pulse[2])
         w_next_y = (r_cur_y == '0) ? (WRAP ? Y_LAST : '0) : r_cur_y - 1'b1;
   end

   assign w_move      = (w_next_x != r_cur_x) | (w_next_y != r_cur_y);
   assign w_slot_free = ~r_px_valid | px_ready;
   assign w_launch    = w_move & w_slot_free;
   assign w_drop      = w_move & ~w_slot_free;
   assign w_color     = r_brush_s2 ? {{CH_BITS{r_rgb_s2[2]}}, {CH_BITS{r_rgb_s2[1]}},
                                      {CH_BITS{r_rgb_s2[0]}}} : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_s1    <= '0;
         r_btn_s2    <= '0;
         r_rgb_s1    <= '0;
         r_rgb_s2    <= '0;
         r_brush_s1  <= 1'b0;
         r_brush_s2  <= 1'b0;
         r_btn_deb   <= '0;
         r_btn_deb_q <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
         r_cur_x     <= '0;
         r_cur_y     <= '0;
         r_px_x      <= '0;
         r_px_y      <= '0;
         r_px_color  <= '0;
         r_px_valid  <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_btn_s1    <= ~btn_n;
         r_btn_s2    <= r_btn_s1;
         r_rgb_s1    <= rgb_sel;
         r_rgb_s2    <= r_rgb_s1;
         r_brush_s1  <= brush;
         r_brush_s2  <= r_brush_s1;
         r_btn_deb_q <= r_btn_deb;

         // A button flips only after DEB_CYCLES consecutive disagreeing samples.
         for (int i = 0; i < 4; i++) begin
            if (r_btn_s2[i] != r_btn_deb[i]) begin
               if (r_cnt[i] == CNT_LAST) begin
                  r_btn_deb[i] <= ~r_btn_deb[i];
                  r_cnt[i]     <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 1'b1;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end

         if (w_launch) begin
            r_cur_x    <= w_next_x;
            r_cur_y    <= w_next_y;
            r_px_x     <= w_next_x;
            r_px_y     <= w_next_y;
            r_px_color <= w_color;
            r_px_valid <= 1'b1;
         end else if (px_ready) begin
            r_px_valid <= 1'b0;
         end

         if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign px_valid = r_px_valid;
   assign px_x     = r_px_x;
   assign px_y     = r_px_y;
   assign px_color = r_px_color;
   assign cur_x    = r_cur_x;
   assign cur_y    = r_cur_y;
   assign btn_deb  = r_btn_deb;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_canvas_cursor_ctrl.sv
// Bench for canvas_cursor_ctrl: expected pixel writes are queued by the stimulus and popped by a monitor on each handshake.
module tb_canvas_cursor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_n = 4'hF;
   logic [2:0] rgb_sel = 3'b000;
   logic       brush = 1'b1;
   logic       px_ready = 1'b0;
   logic       px_valid;
   logic [5:0] px_x, px_y, cur_x, cur_y;
   logic [2:0] px_color;
   logic [3:0] btn_deb;
   logic [7:0] drop_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [14:0] exp_q [$];

   canvas_cursor_ctrl dut (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .rgb_sel(rgb_sel), .brush(brush),
      .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
      .px_color(px_color), .cur_x(cur_x), .cur_y(cur_y), .btn_deb(btn_deb),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cur_x"}, 32'(cur_x), 0);
      check({tag, "_cur_y"}, 32'(cur_y), 0);
      check({tag, "_px_valid"}, 32'(px_valid), 0);
      check({tag, "_px_xyc"}, 32'({px_x, px_y, px_color}), 0);
      check({tag, "_btn_deb"}, 32'(btn_deb), 0);
      check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Hold a press long enough to debounce and launch, then release and let it settle.
   task automatic press(input logic [3:0] mask, input bit expect_write, input logic [14:0] exp);
      if (expect_write) exp_q.push_back(exp);
      btn_n = ~mask;
      repeat (8) tick();
      btn_n = 4'hF;
      repeat (10) tick();
   endtask

   // Monitor: every accepted write must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && px_valid && px_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got x=%0d y=%0d c=%0h, expected none", px_x, px_y, px_color);
            end else begin
               check("px_write", 32'({px_x, px_y, px_color}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      bit seen_valid;
      repeat (2) tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // Latency: press sampled at edge E moves the cursor at E+6.
      rgb_sel  = 3'b100;
      brush    = 1'b1;
      px_ready = 1'b1;
      exp_q.push_back({6'd1, 6'd0, 3'b100});
      btn_n = 4'b1101;
      repeat (6) tick();
      check("pre_launch_cur_x", 32'(cur_x), 0);
      check("pre_launch_valid", 32'(px_valid), 0);
      tick();
      check("launch_cur_x", 32'(cur_x), 1);
      check("launch_valid", 32'(px_valid), 1);
      check("launch_px_xy", 32'({px_x, px_y}), 32'({6'd1, 6'd0}));
      check("launch_color", 32'(px_color), 32'(3'b100));
      check("launch_btn_deb", 32'(btn_deb), 32'(4'b0010));
      tick();
      check("valid_cleared", 32'(px_valid), 0);
      repeat (3) tick();
      btn_n = 4'hF;
      repeat (10) tick();

      // Bounce on up: 2-sample glitches never debounce.
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         btn_n[3] = ~btn_n[3];
         tick();
         seen_valid |= px_valid;
         tick();
         seen_valid |= px_valid;
      end
      btn_n = 4'hF;
      repeat (10) tick();
      check("bounce_cur_y", 32'(cur_y), 0);
      check("bounce_no_valid", 32'(seen_valid), 0);
      check("bounce_btn_deb", 32'(btn_deb), 0);

      // Up at the top row.
`ifdef CANVAS_WRAP_EN
      press(4'b1000, 1'b1, {6'd1, 6'd63, 3'b100});
      check("wrap_cur_y", 32'(cur_y), 63);
      press(4'b0100, 1'b1, {6'd1, 6'd0, 3'b100});
      check("wrap_back_cur_y", 32'(cur_y), 0);
`else
      press(4'b1000, 1'b0, '0);
      check("clamp_cur_y", 32'(cur_y), 0);
      check("clamp_no_valid", 32'(px_valid), 0);
`endif
      check("clamp_drop_cnt", 32'(drop_cnt), 0);

      // Walk to (5,5).
      for (int i = 2; i <= 5; i++) press(4'b0010, 1'b1, {6'(i), 6'd0, 3'b100});
      for (int i = 1; i <= 5; i++) press(4'b0100, 1'b1, {6'd5, 6'(i), 3'b100});
      check("walk_cur", 32'({cur_x, cur_y}), 32'({6'd5, 6'd5}));

      // Up+down together cancel.
      press(4'b1100, 1'b0, '0);
      check("cancel_cur", 32'({cur_x, cur_y}), 32'({6'd5, 6'd5}));
      check("cancel_no_valid", 32'(px_valid), 0);

      // Eraser paints colour 0.
      brush = 1'b0;
      press(4'b0010, 1'b1, {6'd6, 6'd5, 3'b000});
      check("erase_cur", 32'({cur_x, cur_y}), 32'({6'd6, 6'd5}));

      // Backpressure: first press launches, next two drop.
      do_reset();
      check_zero("reset2");
      rgb_sel  = 3'b011;
      brush    = 1'b1;
      px_ready = 1'b0;
      press(4'b0010, 1'b1, {6'd1, 6'd0, 3'b011});
      check("bp_first_valid", 32'(px_valid), 1);
      check("bp_first_drop", 32'(drop_cnt), 0);
      press(4'b0010, 1'b0, '0);
      press(4'b0010, 1'b0, '0);
      check("bp_drop_cnt", 32'(drop_cnt), 2);
      check("bp_cur_x", 32'(cur_x), 1);
      check("bp_valid_held", 32'(px_valid), 1);
      check("bp_px_stable", 32'({px_x, px_y, px_color}), 32'({6'd1, 6'd0, 3'b011}));

      // Reset while a write is pending: dropped, never replayed.
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      repeat (2) tick();
      rst_n    = 1'b1;
      px_ready = 1'b1;
      repeat (5) tick();
      check_zero("postreset");

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
